// File: rtl/period_monitor_pkg.sv
// ============================================================================
//  Module      : period_monitor_pkg
//  Description : Shared state encoding and default sizing for period_monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package period_monitor_pkg;

    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_LOCK_COUNT = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EDGE = 2'd1,
        MEASURE   = 2'd2,
        LOCKED    = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/period_monitor_rise_detect.sv
// ============================================================================
//  Module      : rise_detect
//  Description : Registers the monitored waveform and flags its rising edges;
//                rise_o is combinational, edge_pulse_o is rise_o delayed by one.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rise_detect (
    input  logic CLK,
    input  logic NOT_RESET,
    input  logic in_i,
    output logic rise_o,
    output logic edge_pulse_o
);

    logic in_q;
    logic edge_pulse_q;

    assign rise_o       = in_i & ~in_q;
    assign edge_pulse_o = edge_pulse_q;

    always_ff @(posedge CLK or negedge NOT_RESET) begin
        if (!NOT_RESET) begin
            in_q         <= 1'b0;
            edge_pulse_q <= 1'b0;
        end else begin
            in_q         <= in_i;
            edge_pulse_q <= rise_o;
        end
    end

endmodule

`default_nettype wire

// File: rtl/period_monitor.sv
// ============================================================================
//  Module      : period_monitor
//  Description : Measures the rising-edge period of a divided waveform, flags
//                mismatches against an expected period, detects missing edges
//                and reports lock after LOCK_COUNT consecutive matches.
//                Optional macro PERIOD_MONITOR_STICKY_ERR_EN makes mismatch
//                sticky until reset or en=0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module period_monitor
    import period_monitor_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int LOCK_COUNT = DEFAULT_LOCK_COUNT
) (
    input  logic             CLK,
    input  logic             NOT_RESET,
    input  logic             en,
    input  logic             in,
    input  logic [WIDTH-1:0] expected_period,
    output logic             edge_pulse,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             mismatch,
    output logic             timeout,
    output logic             locked
);

    localparam int               MW       = $clog2(LOCK_COUNT + 1);
    localparam logic [MW-1:0]    LOCK_VAL = MW'(LOCK_COUNT);
    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    state_e           state_q;
    logic [WIDTH-1:0] cnt_q;
    logic [MW-1:0]    match_q;
    logic [WIDTH-1:0] period_q;
    logic             period_valid_q;
    logic             mismatch_q;
    logic             timeout_q;

    logic             rise;
    logic             period_ok;
    logic             mismatch_d;
    logic [MW-1:0]    match_d;

    rise_detect u_rise_detect (
        .CLK          (CLK),
        .NOT_RESET    (NOT_RESET),
        .in_i         (in),
        .rise_o       (rise),
        .edge_pulse_o (edge_pulse)
    );

    // cnt_q equals the cycles elapsed since the previous rise, so it is the period
    assign period_ok = (cnt_q == expected_period);
    assign match_d   = (match_q == LOCK_VAL) ? match_q : match_q + 1'b1;

`ifdef PERIOD_MONITOR_STICKY_ERR_EN
    assign mismatch_d = mismatch_q | ~period_ok;
`else
    assign mismatch_d = ~period_ok;
`endif

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign mismatch     = mismatch_q;
    assign timeout      = timeout_q;
    assign locked       = (state_q == LOCKED);

    always_ff @(posedge CLK or negedge NOT_RESET) begin
        if (!NOT_RESET) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            match_q        <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            mismatch_q     <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            period_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
            if (!en) begin
                state_q    <= IDLE;
                cnt_q      <= '0;
                match_q    <= '0;
                mismatch_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= WAIT_EDGE;
                    end
                    WAIT_EDGE: begin
                        if (rise) begin
                            cnt_q   <= CNT_ONE;
                            state_q <= MEASURE;
                        end
                    end
                    MEASURE, LOCKED: begin
                        if (rise) begin
                            period_q       <= cnt_q;
                            period_valid_q <= 1'b1;
                            cnt_q          <= CNT_ONE;
                            mismatch_q     <= mismatch_d;
                            if (period_ok) begin
                                match_q <= match_d;
                                if (match_d == LOCK_VAL) begin
                                    state_q <= LOCKED;
                                end
                            end else begin
                                match_q <= '0;
                                state_q <= MEASURE;
                            end
                        end else if (cnt_q == CNT_MAX) begin
                            timeout_q  <= 1'b1;
                            mismatch_q <= 1'b1;
                            match_q    <= '0;
                            cnt_q      <= '0;
                            state_q    <= WAIT_EDGE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/period_monitor.md
PERIOD_MONITOR -- requirements
Module: period_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 8: width of the period counter and the period fields.
REQ-002 SHALL have parameter LOCK_COUNT, default 4: consecutive matching periods required to lock.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port NOT_RESET  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  monitor enable; low forces IDLE synchronously.
REQ-006 SHALL have port in  input  1  divided waveform from the upstream divider FSM, synchronous to CLK.
REQ-007 SHALL have port expected_period  input  WIDTH  nominal period in CLK cycles; legal range 2..2^WIDTH-2.
REQ-008 SHALL have port edge_pulse  output  1  one-cycle pulse per detected rising edge of in.
REQ-009 SHALL have port period  output  WIDTH  last measured period, held between updates.
REQ-010 SHALL have port period_valid  output  1  one-cycle strobe when period updates.
REQ-011 SHALL have port mismatch  output  1  measured period differs from expected_period.
REQ-012 SHALL have port timeout  output  1  one-cycle pulse when no edge arrives before the counter saturates.
REQ-013 SHALL have port locked  output  1  high while LOCK_COUNT consecutive matches hold.

Function
REQ-014 SHALL register in into in_q every cycle; rise = in & ~in_q; edge_pulse SHALL be rise registered (1-cycle latency).
REQ-015 SHALL use FSM states IDLE, WAIT_EDGE, MEASURE, LOCKED.
REQ-016 Transitions: IDLE->WAIT_EDGE when en=1; WAIT_EDGE->MEASURE on rise; MEASURE->LOCKED when the match counter reaches LOCK_COUNT; LOCKED->MEASURE on any mismatch; any state->IDLE when en=0 (priority over everything except reset).
REQ-017 On the first rise (WAIT_EDGE), the counter SHALL load 1 with no period_valid.
REQ-018 In MEASURE/LOCKED, the counter SHALL increment each cycle; on rise, period <= counter, period_valid=1, counter <= 1 (in/1/1/0 repeating, i.e. a divide-by-3 pattern, yields period=3).
REQ-019 On period_valid, mismatch SHALL be set to (period != expected_period) and held until the next period_valid; the match counter SHALL increment (saturating at LOCK_COUNT) on match and clear on mismatch.
REQ-020 locked SHALL equal (state == LOCKED); it SHALL fall in the cycle after a mismatching period_valid.
REQ-021 When the counter reaches 2^WIDTH-1 without a rise: timeout pulse, mismatch=1, match counter cleared, state->WAIT_EDGE; period is unchanged.
REQ-022 A rise coinciding with saturation SHALL be treated as an edge (no timeout).
REQ-023 A change to expected_period SHALL take effect at the next period_valid only.
REQ-024 Entering IDLE SHALL clear the counter, match counter, mismatch and locked; period SHALL hold.

Reset
REQ-025 NOT_RESET=0 SHALL immediately force state=IDLE, in_q=0, all counters 0, and all outputs 0, including period.
REQ-026 Reset deassertion mid-waveform SHALL restart from IDLE; the first edge afterwards yields no period_valid.

Configuration
REQ-027 With PERIOD_MONITOR_STICKY_ERR_EN defined, mismatch SHALL be sticky once set, clearing only on reset or en=0; without it, behaviour per REQ-019.

Structure
REQ-028 Package period_monitor_pkg SHALL hold the state enum type and the default WIDTH/LOCK_COUNT constants.
REQ-029 Edge detection (in_q, rise, edge_pulse) SHALL be a sub-module named rise_detect.

Verification
REQ-030 Divide-by-3 pattern, expected=3, en=1 -> period=3 on every period_valid; mismatch=0; locked rises after the 4th valid period.
REQ-031 Same pattern, expected=4 -> mismatch=1 at the first period_valid; locked never rises.
REQ-032 in held high after lock, WIDTH=8 -> timeout at counter 255; locked=0; state WAIT_EDGE; period stays 3.
REQ-033 NOT_RESET pulsed low in LOCKED between clock edges -> all outputs 0 immediately; relock needs the first edge plus 4 matching periods.
REQ-034 With PERIOD_MONITOR_STICKY_ERR_EN: one period of 4 among period-3 traffic -> mismatch stays 1 until en=0; without the macro, mismatch clears at the next good period.
